seg_display_scan: RTL and testbench

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

---
 rtl/seg_display_scan_pkg.sv | 28 ++
 rtl/seg_display_scan_seg7_decode.sv | 27 ++
 rtl/seg_display_scan.sv | 105 ++++++++++
 tb/tb_seg_display_scan.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seg_display_scan_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_display_scan_pkg;

  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_BLINK_FRAMES = 125;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low one-hot digit select for a scan index.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_display_scan_seg7_decode.sv
// Combinational 4-bit value to active-low 7-segment pattern.
// Values above 9 show a dash so invalid BCD is visible on the display.
module seg7_decode
  import seg_display_scan_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed 4-digit 7-segment driver with per-digit blink,
// decimal points and leading-zero blanking; outputs are registered.
module seg_display_scan
  import seg_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_mask,
  input  logic [3:0] blink_mask,
  input  logic       lz_blank,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             blink_q, blink_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick;
  logic             frame_done;
  logic [3:0]       digit;
  logic [6:0]       digit_seg;
  logic             blank;

  seg7_decode u_decode (
    .value (digit),
    .seg   (digit_seg)
  );

  always_comb begin
    tick       = (cnt_q == CNT_MAX);
    frame_done = tick && (idx_q == 2'd3);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    frm_d      = frm_q;
    blink_d    = blink_q;
    if (frame_done) begin
      if (frm_q == FRM_MAX) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // Digit inputs are read live each cycle, not latched per scan slot.
  always_comb begin
    digit = d0;
    case (idx_q)
      2'd0: digit = d0;
      2'd1: digit = d1;
      2'd2: digit = d2;
      2'd3: digit = d3;
      default: digit = d0;
    endcase
    blank = (blink_q && blink_mask[idx_q]) ||
            ((idx_q == 2'd3) && lz_blank && (d3 == 4'd0));
    anode_d = blank ? ANODE_OFF : anode_sel(idx_q);
    seg_d   = blank ? SEG_BLANK : digit_seg;
    dp_d    = blank ? 1'b1 : ~dp_mask[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: expected {anode,seg,dp} per clock is
// derived from elapsed time since reset release and queued for the monitor.
module tb_seg_display_scan;

  localparam int DIV = 4;
  localparam int BF  = 2;
  localparam logic [11:0] ALL_OFF = 12'hFFF;
  localparam logic [6:0] SEG_REF [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0] dp_mask = '0, blink_mask = '0;
  logic       lz_blank = 1'b0;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  seg_display_scan #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .lz_blank   (lz_blank),
    .anode      (anode),
    .seg        (seg),
    .dp         (dp)
  );

  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;  // clock edges seen since reset release, before the next one

  // Reference: slot and blink phase come from elapsed time alone.
  function automatic logic [11:0] model(input int c);
    int         idx;
    int         ph;
    logic [3:0] v;
    logic [3:0] an;
    logic [6:0] sg;
    logic       blank;
    idx   = (c / DIV) % 4;
    ph    = (c / (4 * DIV * BF)) % 2;
    v     = (idx == 0) ? d0 : (idx == 1) ? d1 : (idx == 2) ? d2 : d3;
    blank = (ph == 1 && blink_mask[idx]) || (idx == 3 && lz_blank && d3 == 4'd0);
    if (blank) return ALL_OFF;
    an      = 4'b1111;
    an[idx] = 1'b0;
    sg      = (v > 4'd9) ? 7'b0111111 : SEG_REF[v];
    return {an, sg, ~dp_mask[idx]};
  endfunction

  // Driver tasks
  task automatic drive(input logic [3:0] a, b, c, d, dpm, bm, input logic lz);
    @(negedge clk);
    rst = 1'b0;
    d0 = a; d1 = b; d2 = c; d3 = d;
    dp_mask = dpm; blink_mask = bm; lz_blank = lz;
    exp_q.push_back(model(cyc));
    cyc++;
  endtask

  task automatic drive_rand();
    logic [3:0] dd3;
    dd3 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), dd3, 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic hold_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(ALL_OFF);
    end
    cyc = 0;
  endtask

  // Asynchronous reset between edges: outputs must clear at once.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({anode, seg, dp} !== ALL_OFF) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", {anode, seg, dp}, ALL_OFF);
    end
    exp_q.push_back(ALL_OFF);
    cyc = 0;
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    logic [11:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({anode, seg, dp} !== e) begin
        n_err++;
        $display("FAIL scan_out t=%0t: got anode=%b seg=%b dp=%b expected anode=%b seg=%b dp=%b",
                 $time, anode, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  end

  initial begin
    int guard;
    hold_reset(3);
    // Plain 1,2,3,4 scan over more than two frames
    repeat (36) drive(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'b0000, 1'b0);
    // Randomized inputs, several blink phases
    repeat (250) drive_rand();
    // Zero-extended mod-6 tens digit and leading-zero blanking
    hold_reset(1);
    repeat (16) drive(4'd0, 4'b0101, 4'd0, 4'd0, 4'b0000, 4'b0000, 1'b1);
    // Dash for 0xC and decimal point on digit 2
    repeat (16) drive(4'd0, 4'd0, 4'hC, 4'd0, 4'b0100, 4'b0000, 1'b0);
    // Blink of digit 0 from reset: lit, blank after 32, lit again at 64
    hold_reset(2);
    repeat (72) drive(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'b0001, 1'b0);
    // Reset in the middle of digit 2's slot, then full rescan
    guard = 0;
    do begin
      drive(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'b0000, 1'b0);
      guard++;
    end while (!(((cyc / DIV) % 4 == 2) && (cyc % DIV == 2)) && guard < 64);
    pulse_reset();
    hold_reset(1);
    repeat (20) drive(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'b0000, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
